// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch state encodings, default reset PC and address helpers
package fetch_unit_pkg;

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_DROP} fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one outstanding imem request into a one-entry decode buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    output logic        o_misalign
);

    fetch_state_t state, state_d;
    logic [31:0] pc, pc_d, redir_pc, redir_d, target;
    logic can_take, redirect, capture, valid_d, busy;

    assign target      = word_align(i_b_pc);
    assign can_take    = !o_valid | i_ready;
    assign busy        = (state == S_WAIT) | (state == S_DROP);
    assign redirect    = i_b_taken & (state != S_BOOT);
    assign o_imem_req  = (state == S_FETCH) ? (can_take & !i_b_taken) : busy;
    assign o_imem_addr = pc;
    assign capture     = o_imem_req & i_imem_ack & !i_b_taken & (state != S_DROP);
    assign valid_d     = redirect ? 1'b0 : capture ? 1'b1 : (o_valid & i_ready) ? 1'b0 : o_valid;
    assign redir_d     = (busy & i_b_taken) ? target : redir_pc;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        case (state)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                state_d = (o_imem_req & !i_imem_ack) ? S_WAIT : S_FETCH;
                pc_d    = i_b_taken ? target : capture ? pc + 32'd4 : pc;
            end
            S_WAIT: begin
                state_d = i_imem_ack ? S_FETCH : i_b_taken ? S_DROP : S_WAIT;
                pc_d    = !i_imem_ack ? pc : i_b_taken ? target : pc + 32'd4;
            end
            S_DROP: begin
                // a redirect arriving with the ack is newer than the stored one
                state_d = i_imem_ack ? S_FETCH : S_DROP;
                pc_d    = !i_imem_ack ? pc : i_b_taken ? target : redir_pc;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            redir_pc   <= RESET_PC;
            o_valid    <= 1'b0;
            o_instr    <= 32'h0;
            o_pc       <= 32'h0;
            o_misalign <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            redir_pc   <= redir_d;
            o_valid    <= valid_d;
            o_misalign <= redirect & (i_b_pc[1:0] != 2'b00);
            if (capture) begin
                o_instr <= i_imem_data;
                o_pc    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed vectors plus a reset-during-wait sequence
module tb_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic        tk;
        logic [31:0] bpc;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b_taken = 1'b0;
    logic [31:0] b_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready = 1'b0;
    logic        misalign;

    int total = 0;
    int passed = 0;
    vec_t vecs[27];

    fetch_unit dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_b_taken   (b_taken),
        .i_b_pc      (b_pc),
        .o_imem_req  (imem_req),
        .o_imem_addr (imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_data (imem_data),
        .o_valid     (valid),
        .o_instr     (instr),
        .o_pc        (pc),
        .i_ready     (ready),
        .o_misalign  (misalign)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic tk, input logic [31:0] bpc, input logic ack,
                                input logic [31:0] data, input logic rdy, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic e_mis);
        vec_t v;
        v.tk = tk; v.bpc = bpc; v.ack = ack; v.data = data; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        vecs[0]  = mk(L, 32'h0,        H, 32'h11, H,  L, 32'h0,        L, 32'h0,  32'h0,        L);
        vecs[1]  = mk(L, 32'h0,        H, 32'h11, H,  H, 32'h0,        H, 32'h11, 32'h0,        L);
        vecs[2]  = mk(L, 32'h0,        H, 32'h22, H,  H, 32'h4,        H, 32'h22, 32'h4,        L);
        vecs[3]  = mk(L, 32'h0,        H, 32'h33, H,  H, 32'h8,        H, 32'h33, 32'h8,        L);
        vecs[4]  = mk(L, 32'h0,        H, 32'h44, L,  L, 32'hC,        H, 32'h33, 32'h8,        L);
        vecs[5]  = mk(L, 32'h0,        H, 32'h44, L,  L, 32'hC,        H, 32'h33, 32'h8,        L);
        vecs[6]  = mk(L, 32'h0,        H, 32'h44, L,  L, 32'hC,        H, 32'h33, 32'h8,        L);
        vecs[7]  = mk(L, 32'h0,        H, 32'h44, H,  H, 32'hC,        H, 32'h44, 32'hC,        L);
        vecs[8]  = mk(L, 32'h0,        L, 32'h0,  H,  H, 32'h10,       L, 32'h44, 32'hC,        L);
        vecs[9]  = mk(L, 32'h0,        L, 32'h0,  L,  H, 32'h10,       L, 32'h44, 32'hC,        L);
        vecs[10] = mk(L, 32'h0,        L, 32'h0,  H,  H, 32'h10,       L, 32'h44, 32'hC,        L);
        vecs[11] = mk(L, 32'h0,        H, 32'h55, L,  H, 32'h10,       H, 32'h55, 32'h10,       L);
        vecs[12] = mk(L, 32'h0,        L, 32'h0,  H,  H, 32'h14,       L, 32'h55, 32'h10,       L);
        vecs[13] = mk(H, 32'h100,      L, 32'h0,  H,  H, 32'h14,       L, 32'h55, 32'h10,       L);
        vecs[14] = mk(H, 32'h200,      L, 32'h0,  H,  H, 32'h14,       L, 32'h55, 32'h10,       L);
        vecs[15] = mk(L, 32'h0,        H, 32'h66, H,  H, 32'h14,       L, 32'h55, 32'h10,       L);
        vecs[16] = mk(L, 32'h0,        H, 32'h77, H,  H, 32'h200,      H, 32'h77, 32'h200,      L);
        vecs[17] = mk(H, 32'h300,      H, 32'h88, H,  L, 32'h204,      L, 32'h77, 32'h200,      L);
        vecs[18] = mk(L, 32'h0,        H, 32'h99, H,  H, 32'h300,      H, 32'h99, 32'h300,      L);
        vecs[19] = mk(H, 32'h106,      L, 32'h0,  L,  L, 32'h304,      L, 32'h99, 32'h300,      H);
        vecs[20] = mk(L, 32'h0,        H, 32'hAA, H,  H, 32'h104,      H, 32'hAA, 32'h104,      L);
        vecs[21] = mk(H, 32'hFFFFFFFC, L, 32'h0,  H,  L, 32'h108,      L, 32'hAA, 32'h104,      L);
        vecs[22] = mk(L, 32'h0,        H, 32'hBB, H,  H, 32'hFFFFFFFC, H, 32'hBB, 32'hFFFFFFFC, L);
        vecs[23] = mk(L, 32'h0,        H, 32'hCC, H,  H, 32'h0,        H, 32'hCC, 32'h0,        L);
        vecs[24] = mk(L, 32'h0,        L, 32'h0,  H,  H, 32'h4,        L, 32'hCC, 32'h0,        L);
        vecs[25] = mk(H, 32'h400,      H, 32'hDD, H,  H, 32'h4,        L, 32'hCC, 32'h0,        L);
        vecs[26] = mk(L, 32'h0,        H, 32'hEE, H,  H, 32'h400,      H, 32'hEE, 32'h400,      L);

        repeat (2) @(negedge clk);
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_mis",   {31'h0, misalign}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            b_taken = vecs[i].tk; b_pc = vecs[i].bpc; imem_ack = vecs[i].ack;
            imem_data = vecs[i].data; ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_req", i),  {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
            chk($sformatf("v%0d_pc", i),    pc, vecs[i].e_pc);
            chk($sformatf("v%0d_mis", i),   {31'h0, misalign}, {31'h0, vecs[i].e_mis});
            @(negedge clk);
        end

        // enter S_WAIT at 0x404, then reset asynchronously mid-cycle
        b_taken = 1'b0; imem_ack = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        chk("wait_req",  {31'h0, imem_req}, 32'h1);
        chk("wait_addr", imem_addr, 32'h404);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'h0, imem_req}, 32'h0);
        chk("arst_addr",  imem_addr, 32'h0);
        chk("arst_valid", {31'h0, valid}, 32'h0);
        chk("arst_instr", instr, 32'h0);
        imem_ack = 1'b1; imem_data = 32'hFF;
        @(posedge clk); #1;
        chk("late_ack_valid", {31'h0, valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; imem_data = 32'h123;
        #1;
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        chk("boot_valid", {31'h0, valid}, 32'h0);
        @(negedge clk);
        imem_data = 32'h321;
        #1;
        chk("refetch_req",  {31'h0, imem_req}, 32'h1);
        chk("refetch_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        chk("refetch_valid", {31'h0, valid}, 32'h1);
        chk("refetch_instr", instr, 32'h321);
        chk("refetch_pc",    pc, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
